// File: rtl/mesi_line_array_if.sv
// rtl/mesi_line_array_if.sv - CPU, snoop, write-back and debug signal bundle for mesi_line_array
interface mesi_line_array_if #(
  parameter int IDX_W = 2
);
  logic             cpu_valid;
  logic [1:0]       cpu_op;
  logic [IDX_W-1:0] cpu_idx;
  logic             cpu_shared;
  logic             cpu_ready;
  logic             snoop_valid;
  logic [1:0]       snoop_op;
  logic [IDX_W-1:0] snoop_idx;
  logic             snoop_ready;
  logic [1:0]       bus_out;
  logic             mem_req;
  logic [1:0]       mem_out;
  logic [IDX_W-1:0] mem_idx;
  logic             mem_ack;
  logic [IDX_W-1:0] dbg_idx;
  logic [1:0]       dbg_state;

  modport slave (
    input  cpu_valid, cpu_op, cpu_idx, cpu_shared,
    input  snoop_valid, snoop_op, snoop_idx, mem_ack, dbg_idx,
    output cpu_ready, snoop_ready, bus_out, mem_req, mem_out, mem_idx, dbg_state
  );

  modport master (
    output cpu_valid, cpu_op, cpu_idx, cpu_shared,
    output snoop_valid, snoop_op, snoop_idx, mem_ack, dbg_idx,
    input  cpu_ready, snoop_ready, bus_out, mem_req, mem_out, mem_idx, dbg_state
  );
endinterface

// File: rtl/mesi_line_array.sv
// rtl/mesi_line_array.sv - per-line MESI state array with snoop-priority arbitration and write-back handshake
module mesi_line_array #(
  parameter int IDX_W = 2
) (
  input logic             clock,
  input logic             Reset,
  mesi_line_array_if.slave io
);
  localparam int LINES = 2 ** IDX_W;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  localparam logic [1:0] BUS_IDLE = 2'b00;
  localparam logic [1:0] BUS_RD   = 2'b01;
  localparam logic [1:0] BUS_WR   = 2'b10;
  localparam logic [1:0] BUS_INV  = 2'b11;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] WB_WAIT = 1'b1;

  logic [LINES-1:0][1:0] lines_q, lines_d;
  logic [0:0]            fsm_q, fsm_d;
  logic [1:0]            bus_q, bus_d;
  logic                  mem_req_q, mem_req_d;
  logic [IDX_W-1:0]      mem_idx_q, mem_idx_d;

  logic             idle;
  logic             snoop_live;
  logic             snoop_acc;
  logic             cpu_acc;
  logic             cpu_ready_c;
  logic [IDX_W-1:0] ev_idx;
  logic [1:0]       cur;
  logic [1:0]       nxt;
  logic             wb;

  always_comb begin
    idle        = (fsm_q == IDLE);
    // A no-op snoop is accepted but must not steal the cycle from the CPU.
    snoop_live  = io.snoop_valid && (io.snoop_op != 2'b00);
    cpu_ready_c = idle && !snoop_live;
    snoop_acc   = idle && snoop_live;
    cpu_acc     = cpu_ready_c && io.cpu_valid;
    ev_idx      = snoop_acc ? io.snoop_idx : io.cpu_idx;
    cur         = lines_q[ev_idx];
    nxt         = cur;
    wb          = 1'b0;
    bus_d       = BUS_IDLE;

    if (snoop_acc) begin
      wb = (cur == ST_M);
      if (io.snoop_op == 2'b01) begin
        if (cur != ST_I) nxt = ST_S;
      end else begin
        nxt = ST_I;
      end
    end else if (cpu_acc) begin
      case (io.cpu_op)
        2'b00: begin
          if (cur == ST_I) begin
            nxt   = io.cpu_shared ? ST_S : ST_E;
            bus_d = BUS_RD;
          end
        end
        2'b01: begin
          nxt = ST_M;
          if (cur == ST_I)      bus_d = BUS_WR;
          else if (cur == ST_S) bus_d = BUS_INV;
        end
        2'b10: begin
          nxt = ST_I;
          wb  = (cur == ST_M);
        end
        default: ;
      endcase
    end

    lines_d         = lines_q;
    lines_d[ev_idx] = nxt;

    fsm_d     = fsm_q;
    mem_req_d = mem_req_q;
    mem_idx_d = mem_idx_q;
    if (wb) begin
      fsm_d     = WB_WAIT;
      mem_req_d = 1'b1;
      mem_idx_d = ev_idx;
    end else if (!idle && io.mem_ack) begin
      fsm_d     = IDLE;
      mem_req_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      lines_q   <= '0;
      fsm_q     <= IDLE;
      bus_q     <= BUS_IDLE;
      mem_req_q <= 1'b0;
      mem_idx_q <= '0;
    end else begin
      lines_q   <= lines_d;
      fsm_q     <= fsm_d;
      bus_q     <= bus_d;
      mem_req_q <= mem_req_d;
      mem_idx_q <= mem_idx_d;
    end
  end

  assign io.cpu_ready   = cpu_ready_c;
  assign io.snoop_ready = idle;
  assign io.bus_out     = bus_q;
  assign io.mem_req     = mem_req_q;
  assign io.mem_out     = mem_req_q ? 2'b10 : 2'b00;
  assign io.mem_idx     = mem_idx_q;
  assign io.dbg_state   = lines_q[io.dbg_idx];
endmodule

// File: doc/mesi_line_array.md
Name: mesi_line_array

Overview:
- Multi-line MESI coherence controller. It holds a 2-bit MESI state for each of 2**IDX_W cache lines.
- It services CPU requests (read, write, evict) and bus snoops (read miss, write miss, invalidate) against individually indexed lines.
- It drives the coherence bus code and a memory write-back request with a req/ack handshake.
- It sits between the cache datapath/CPU side and the shared snoop bus. It is the parametrised successor of the single-line MESI FSM.

Parameters:
- IDX_W, 2, line index width. Line count LINES = 2**IDX_W (derived, not overridable).

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- Reset, input, 1, asynchronous, active-high reset.
- cpu_valid, input, 1, CPU request present.
- cpu_op, input, 2, CPU operation: 00 read, 01 write, 10 evict, 11 reserved.
- cpu_idx, input, IDX_W, line addressed by the CPU request.
- cpu_shared, input, 1, another cache holds the line; sampled only on a read miss.
- cpu_ready, output, 1, CPU request accepted this cycle when cpu_valid=1 (combinational).
- snoop_valid, input, 1, snoop event present.
- snoop_op, input, 2, snoop event: 01 read miss, 10 write miss, 11 invalidate, 00 none.
- snoop_idx, input, IDX_W, line addressed by the snoop.
- snoop_ready, output, 1, snoop accepted this cycle when snoop_valid=1 (combinational).
- bus_out, output, 2, registered bus code: 00 idle, 01 read miss, 10 write miss, 11 invalidate.
- mem_req, output, 1, write-back request (registered level).
- mem_out, output, 2, memory command: 10 write-back while mem_req=1, else 00.
- mem_idx, output, IDX_W, line being written back; valid while mem_req=1.
- mem_ack, input, 1, memory accepts the write-back.
- dbg_idx, input, IDX_W, debug line select.
- dbg_state, output, 2, state of line dbg_idx (combinational): 00 I, 01 S, 10 E, 11 M.

Behaviour:

Reset:
- All lines go to I.
- bus_out=00, mem_req=0, mem_out=00, mem_idx=0.
- Controller goes to IDLE.
- A Reset during WB_WAIT drops mem_req immediately and abandons the write-back.

Controller FSM:
- Two states, IDLE and WB_WAIT.
- snoop_ready = (IDLE).
- cpu_ready = (IDLE) and not (snoop_valid with snoop_op≠00). A snoop always wins; the CPU retries.
- Snoop with snoop_op=00 is accepted and has no effect.

Event handling:
- An accepted event updates the line state on the acceptance edge.
- bus_out takes the event's bus code for exactly one cycle, then returns to 00.
- At most one event is accepted per cycle.

CPU transitions (hit means the line is not I):
- read:
  - I -> S if cpu_shared, else E; bus 01.
  - S/E/M unchanged; bus 00.
- write:
  - I -> M, bus 10.
  - S -> M, bus 11.
  - E -> M silent (bus 00).
  - M -> M silent (bus 00).
- evict:
  - S/E -> I silent.
  - M -> I with write-back.
  - I: no-op.
- op 11: accepted; no state change; bus 00.

Snoop transitions:
- read miss: S stays S; E -> S; M -> S with write-back; I unchanged.
- write miss or invalidate: S/E -> I; M -> I with write-back; I unchanged.
- Snoops never drive bus_out (bus_out stays 00).

Write-back handshake:
- On the acceptance edge of a write-back event: mem_req=1, mem_out=10, mem_idx=line; controller enters WB_WAIT.
- In WB_WAIT, mem_req, mem_out and mem_idx are held stable, and cpu_ready = snoop_ready = 0.
- mem_ack=1 in WB_WAIT: on that edge mem_req=0, mem_out=00, return to IDLE. A new event can be accepted in the following cycle.
- Minimum write-back occupancy is 2 cycles (request cycle plus ack cycle).
- mem_ack in IDLE is ignored.

Latency:
- State visible on dbg_state the cycle after acceptance.
- bus_out valid the cycle after acceptance.
- Lines not addressed by the accepted event never change.

Test Plan:
1. Reset, then CPU read idx 2 with cpu_shared=0 -> next cycle bus_out=01, dbg_state[2]=10 (E); the following cycle bus_out=00.
2. Line 1 in S, CPU write idx 1 -> bus_out=11, line 1=M. Then line 3 in E, CPU write idx 3 -> bus_out=00, line 3=M.
3. Line 0 in M, snoop read miss idx 0 -> line 0=S, mem_req=1, mem_out=10, mem_idx=0. Hold mem_ack=0 for 3 cycles -> outputs stable and cpu_ready=snoop_ready=0. Pulse mem_ack -> mem_req=0 and IDLE next cycle.
4. Same cycle: snoop invalidate idx 1 plus CPU read idx 2 -> cpu_ready=0, line 1 goes S->I, line 2 unchanged. CPU request held -> accepted the next cycle.
5. Line 2 in M, CPU evict idx 2 -> line 2=I, write-back on idx 2. Assert Reset during WB_WAIT -> mem_req=0 immediately and all lines I.
6. IDX_W=3 build: fill lines 0–7 with alternating reads and writes, then snoop write miss on each line -> all lines I. Write-backs occur only on lines that were in M.
